// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with a bounded hold time per owner.
// Every owner change passes through one idle cycle so the mux switches break-before-make.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | no owner; gnt/valid low; picks the next winner after last
// ST_GRANT | owner sel holds the mux; cnt counts held cycles
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    sel_q,   sel_d;
  logic [3:0]    gnt_q,   gnt_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  logic [1:0] idx;
  logic [1:0] win;
  logic       found;
  logic       others;
  logic       owner_req;
  logic       release_now;

  // Scan last+1, last+2, last+3, last so the previous owner has lowest priority.
  always_comb begin
    idx   = '0;
    win   = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign others      = |(req & ~gnt_q);
  assign owner_req   = req[sel_q];
  assign release_now = !owner_req || ((cnt_q == MAX_CNT) && others);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    ready_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        // The first edge after reset removal only arms the arbiter.
        if (ready_q && found) begin
          state_d = ST_GRANT;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          valid_d = 1'b1;
          last_d  = win;
          cnt_d   = CW'(1);
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 2'b11;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD 8 and 1) share stimulus and
// are compared every cycle against a behavioural owner/last/hold-count model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel8, sel1;
  logic [3:0] gnt8, gnt1;
  logic       valid8, valid1;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .sel(sel8), .gnt(gnt8), .valid(valid8)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .sel(sel1), .gnt(gnt1), .valid(valid1)
  );

  always #5 clk = ~clk;

  // Model: index 0 tracks the MAX_HOLD=8 instance, index 1 the MAX_HOLD=1 instance.
  int hold_of [2] = '{8, 1};
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int m_sel   [2];
  int m_armed [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = 3;
      m_held[k]  = 0;
      m_sel[k]   = 0;
      m_armed[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit others;
    if (m_armed[k] == 0) begin
      m_armed[k] = 1;
    end else if (m_owner[k] < 0) begin
      for (int j = 1; j <= 4; j++) begin
        int c;
        c = (m_last[k] + j) % 4;
        if (m_owner[k] < 0 && req[c]) begin
          m_owner[k] = c;
          m_sel[k]   = c;
          m_last[k]  = c;
          m_held[k]  = 1;
        end
      end
    end else begin
      others = (req & ~(4'b0001 << m_owner[k])) != 4'b0000;
      if (!req[m_owner[k]] || (m_held[k] == hold_of[k] && others))
        m_owner[k] = -1;
      else if (m_held[k] < hold_of[k])
        m_held[k]++;
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int k);
    return (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
  endfunction

  task automatic compare_all();
    check("gnt8",   {4'b0, gnt8},   {4'b0, exp_gnt(0)});
    check("sel8",   {6'b0, sel8},   8'(m_sel[0]));
    check("valid8", {7'b0, valid8}, {7'b0, m_owner[0] >= 0});
    check("gnt1",   {4'b0, gnt1},   {4'b0, exp_gnt(1)});
    check("sel1",   {6'b0, sel1},   8'(m_sel[1]));
    check("valid1", {7'b0, valid1}, {7'b0, m_owner[1] >= 0});
    check("onehot8", {7'b0, $onehot0(gnt8)}, 8'd1);
    check("onehot1", {7'b0, $onehot0(gnt1)}, 8'd1);
    check("vld_or8", {7'b0, valid8}, {7'b0, |gnt8});
    check("vld_or1", {7'b0, valid1}, {7'b0, |gnt1});
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [3:0] prev_gnt;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt",   {4'b0, gnt8},   8'h00);
    check("rst_valid", {7'b0, valid8}, 8'h00);
    check("rst_sel",   {6'b0, sel8},   8'h00);

    // Reset release with all requesting: first grant after the second edge, to input 0.
    req = 4'b1111;
    rst = 1'b0;
    step();
    check("arm_gnt8", {4'b0, gnt8}, 8'h00);
    step();
    check("first_gnt8", {4'b0, gnt8}, 8'h01);
    check("first_gnt1", {4'b0, gnt1}, 8'h01);

    // Rotation at MAX_HOLD=8: 8 grant cycles plus one gap per owner.
    steps(9);
    check("rot_1", {4'b0, gnt8}, 8'h02);
    steps(9);
    check("rot_2", {4'b0, gnt8}, 8'h04);
    steps(9);
    check("rot_3", {4'b0, gnt8}, 8'h08);
    steps(9);
    check("rot_0", {4'b0, gnt8}, 8'h01);

    // Single requester keeps the mux indefinitely.
    req = 4'b0000;
    steps(2);
    req = 4'b0100;
    step();
    check("single_gnt", {4'b0, gnt8}, 8'h04);
    check("single_sel", {6'b0, sel8}, 8'h02);
    steps(20);
    check("single_hold", {4'b0, gnt8}, 8'h04);
    check("single_hold1", {4'b0, gnt1}, 8'h04);
    req = 4'b0000;
    step();
    check("single_drop", {4'b0, gnt8}, 8'h00);

    // Early release: last=2, so 0 wins over 1; 0 drops after 3 cycles.
    req = 4'b0011;
    step();
    check("early_gnt0", {4'b0, gnt8}, 8'h01);
    steps(2);
    req = 4'b0010;
    step();
    check("early_gap", {4'b0, gnt8}, 8'h00);
    step();
    check("early_gnt1", {4'b0, gnt8}, 8'h02);
    check("early_sel1", {6'b0, sel8}, 8'h01);

    // Priority from last: owner 2 releases, then 0 beats 2.
    req = 4'b0000;
    step();
    req = 4'b0100;
    steps(3);
    check("pri_own2", {4'b0, gnt8}, 8'h04);
    req = 4'b0001;
    step();
    check("pri_gap", {4'b0, gnt8}, 8'h00);
    req = 4'b0101;
    step();
    check("pri_gnt0", {4'b0, gnt8}, 8'h01);

    // Asynchronous reset mid-grant.
    req = 4'b1111;
    steps(3);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt8",   {4'b0, gnt8},   8'h00);
    check("arst_valid8", {7'b0, valid8}, 8'h00);
    check("arst_sel8",   {6'b0, sel8},   8'h00);
    check("arst_gnt1",   {4'b0, gnt1},   8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    steps(2);
    check("arst_first8", {4'b0, gnt8}, 8'h01);
    check("arst_first1", {4'b0, gnt1}, 8'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      step();
    end

    // MAX_HOLD=1 corner: 0 and 3 alternate with one-cycle gaps.
    req = 4'b0000;
    steps(3);
    req = 4'b1001;
    step();
    prev_gnt = gnt1;
    check("mh1_first", {7'b0, (gnt1 == 4'b0001) || (gnt1 == 4'b1000)}, 8'h01);
    step();
    check("mh1_gap", {4'b0, gnt1}, 8'h00);
    step();
    check("mh1_alt", {4'b0, gnt1 ^ prev_gnt}, 8'h09);
    steps(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4-input/1-output mux datapath among four requesters. It grants one requester at a time and drives the mux `sel` lines to that requester's input. A hold timer bounds how long one requester can keep the mux while others wait. It sits directly in front of the 4:1 mux: `sel` connects to the mux select, and `gnt` returns to the requesters.

## Interface
- `MAX_HOLD`, default 8: maximum grant cycles before forced release when others wait; legal range 1..255.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `req`  input  4  request per mux input `I[n]`; level-sensitive; held high while the requester wants the mux.
- `sel`  output 2  mux select; index of the current or last owner; registered.
- `gnt`  output 4  one-hot grant; all-zero when no owner; registered.
- `valid`  output 1  high when `gnt` is non-zero (mux output belongs to an owner); registered.

## Operation
- State machine has two states, IDLE and GRANT. It keeps a `last` pointer (2 bits, index of the most recent owner) and a hold counter `cnt`, which is `$clog2(MAX_HOLD+1)` bits wide.
- **IDLE behaviour:**
  - If `req` is zero, stay in IDLE with `gnt`=0 and `valid`=0. `sel` keeps its value.
  - Otherwise, pick the first set bit scanning `last+1, last+2, last+3, last` (mod 4). On the edge, load `sel`=winner, `gnt`=one-hot(winner), `valid`=1, `last`=winner, `cnt`=1, and go to GRANT.
- **GRANT behaviour, with owner `o` = `sel`:**
  - **Release condition:** `req[o]`=0, OR (`cnt`==`MAX_HOLD` AND `req` with bit `o` cleared is non-zero).
  - **On release:** next edge clears `gnt` and `valid` and returns to IDLE. `sel` and `last` are unchanged.
  - **Otherwise:** stay in GRANT. `cnt` increments and saturates at `MAX_HOLD`. A sole requester keeps the mux indefinitely.
- There is no direct GRANT-to-GRANT handover. Every release passes through one IDLE cycle with `gnt`=0, which guarantees a break-before-make switch on the mux.
- **Preempted owner:** after a timeout release, its `req` may still be high. It competes in the next IDLE round with lowest priority, because `last`=its index.
- `gnt` is always one-hot or zero, and `valid` == |`gnt` at all times.
- Requests arriving in GRANT have no effect until the next IDLE cycle, except that they enable the timeout condition.

## Timing
- **Reset values (asynchronous assert, any time):**
  - State is IDLE.
  - `gnt`=4'b0000, `valid`=0, `sel`=2'b00, `cnt`=0.
  - `last`=2'b11, so `req[0]` has first priority after reset.
- **Reset deassertion:** deasserting `rst` takes effect at the next rising edge. The first grant can appear on the second edge after deassertion, provided `req` was set before the first edge.
- **Grant latency:** `req` high in IDLE at edge k gives `gnt`/`sel`/`valid` valid after edge k. The combinational mux output `Q` is valid in the same cycle.
- **Release latency:** `req[o]` dropping before edge k gives `gnt`=0 after edge k. The new grant comes after edge k+1.
- **Timeout:** the owner holds the grant for exactly `MAX_HOLD` cycles when a competitor is pending throughout. With `MAX_HOLD`=1, every grant lasts one cycle whenever a competitor is waiting.
- **Simultaneous events:** if the owner drops `req` in the same cycle the timeout hits, it is a single release with identical behaviour.
- **Reset mid-GRANT:** `gnt` clears immediately (asynchronously). The mux output must then be treated as invalid via `valid`=0.

## Test plan
- **Reset:** assert `rst` mid-GRANT with `req`=4'b1111 -> `gnt`=0, `valid`=0, `sel`=0 immediately. After release with `req`=4'b1111, the first grant is `gnt`=4'b0001.
- **Single requester:** `req`=4'b0100 held 20 cycles -> `gnt`=4'b0100 and `sel`=2 after 1 edge, held all 20 cycles, no timeout release. Drop `req` -> `gnt`=0 next edge.
- **Round-robin rotation:** `req`=4'b1111 constant, `MAX_HOLD`=8 -> grant sequence 0,1,2,3,0. Each grant lasts 8 cycles, separated by one `gnt`=0 cycle, giving a period of 36 cycles.
- **Early release:** `req`=4'b0011, owner 0 drops `req[0]` after 3 grant cycles -> `gnt`=0 for 1 cycle, then `gnt`=4'b0010 with `sel`=1.
- **Priority from `last`:** owner 2 releases and `req`=4'b0101 -> next grant goes to 0 (scan order 3,0,1,2), not 2.
- **`MAX_HOLD`=1 corner:** `req`=4'b1001 -> alternating grants 0,3,0,3, each lasting 1 cycle with a 1-cycle gap. Checker confirms `gnt` is never multi-hot and `valid` == |`gnt` at every cycle.
